alu_issue_ctrl: RTL and testbench

Multi-cycle issue and writeback controller that sits directly upstream of `alu_8bit` in the 8-bit CPU. It accepts one decoded instruction at a time over a valid/ready handshake and reads two operands from a 4 x 8-bit register file. It drives the ALU's `a`, `b` and `alu_sel` inputs from registers, then writes `alu_out` back to the destination register and `carry_out` into a flags register. It also supports a load-immediate path that bypasses the ALU.

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_ctrl_if.sv | 25 ++
 rtl/alu_issue_regfile.sv | 52 +++++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue/writeback controller.
package alu_issue_pkg;

  localparam int DW    = 8;
  localparam int NREGS = 4;
  localparam int AW    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Encodings shared with alu_8bit.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decoded-instruction channel into alu_issue_ctrl.
// Handshake: a transfer happens on a rising edge where instr_valid and instr_ready are both 1;
// instr_ready never depends on instr_valid, and fields only need to be stable in that cycle.
interface alu_issue_ctrl_if;
  import alu_issue_pkg::*;

  logic          instr_valid;
  logic          instr_ready;
  logic          instr_ldi;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic [DW-1:0] instr_imm;

  modport master (
    output instr_valid, instr_ldi, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_ldi, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_regfile.sv
// 4 x 8 register file: two read ports sampled into flops on rd_en, one write port,
// and a combinational debug read port. Everything clears on async active-low reset.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [NREGS-1:0][DW-1:0] regs_q, regs_d;
  logic [DW-1:0]            rs1_q, rs1_d;
  logic [DW-1:0]            rs2_q, rs2_d;

  // Read ports see the pre-write contents, so rs == rd uses the old value.
  always_comb begin
    regs_d = regs_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    if (we) regs_d[wr_addr] = wr_data;
    if (rd_en) begin
      rs1_d = regs_q[rs1_addr];
      rs2_d = regs_q[rs2_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      regs_q <= regs_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of alu_8bit: IDLE -> ISSUE -> WRITE for ALU ops, IDLE -> WRITE for LDI.
// Build option ALU_ISSUE_FLAGS_EN: when defined, carry/zero flag registers exist; otherwise flags read 0.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave instr,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [2:0]      alu_sel,
  input  logic [DW-1:0]   alu_out,
  input  logic            carry_out,
  output logic            done,
  output logic            flag_c,
  output logic            flag_z,
  input  logic [AW-1:0]   dbg_addr,
  output logic [DW-1:0]   dbg_data,
  output state_e          dbg_state
);

  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic          ldi_q, ldi_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          rf_rd_en;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic          accept;

  // Gating with rst_n keeps ready low while reset is held.
  assign instr.instr_ready = (state_q == ST_IDLE) && rst_n;
  assign accept            = instr.instr_valid && instr.instr_ready;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ldi_d    = ldi_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    rf_rd_en = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_out;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ldi_d = instr.instr_ldi;
          rd_d  = instr.instr_rd;
          imm_d = instr.instr_imm;
          if (instr.instr_ldi) begin
            state_d = ST_WRITE;
          end else begin
            sel_d    = instr.instr_op;
            rf_rd_en = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WRITE;
      ST_WRITE: begin
        rf_we    = 1'b1;
        rf_wdata = ldi_q ? imm_q : alu_out;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ldi_q   <= 1'b0;
      rd_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ldi_q   <= ldi_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
    end
  end

  alu_issue_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rf_rd_en),
    .rs1_addr (instr.instr_rs1),
    .rs2_addr (instr.instr_rs2),
    .rs1_data (alu_a),
    .rs2_data (alu_b),
    .we       (rf_we),
    .wr_addr  (rd_q),
    .wr_data  (rf_wdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_sel   = sel_q;
  assign done      = (state_q == ST_WRITE);
  assign dbg_state = state_q;

`ifdef ALU_ISSUE_FLAGS_EN
  logic flag_c_q, flag_c_d;
  logic flag_z_q, flag_z_d;

  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (state_q == ST_WRITE && !ldi_q) begin
      flag_c_d = carry_out;
      flag_z_d = (alu_out == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`else
  logic unused_carry;
  assign unused_carry = carry_out;
  assign flag_c       = 1'b0;
  assign flag_z       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural alu_8bit model in the loop.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int W = 12; // {rd[1:0], data[7:0], c, z}
`ifdef ALU_ISSUE_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if bus();
  logic [7:0] alu_a, alu_b, alu_out, dbg_data;
  logic [2:0] alu_sel;
  logic       carry_out, done, flag_c, flag_z;
  logic [1:0] dbg_addr, dbg_addr_mon, dbg_addr_tb;
  logic       dbg_tb_own;
  state_e     dbg_state;

  assign dbg_addr = dbg_tb_own ? dbg_addr_tb : dbg_addr_mon;

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .done      (done),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      OP_SHL:  return {a[7], a[6:0], 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  always_comb {carry_out, alu_out} = alu_ref(alu_sel, alu_a, alu_b);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference architectural state
  logic [7:0] ref_regs [4];
  logic       ref_c, ref_z;

  function automatic logic [W-1:0] model(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    logic [8:0] r;
    if (ldi) return {rd, imm, ref_c, ref_z};
    r = alu_ref(op, ref_regs[rs1], ref_regs[rs2]);
    return {rd, r[7:0], r[8], (r[7:0] == 8'h00)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         pend = 1'b0;
  logic [W-1:0] pend_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cyc_q.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("wb_data", 32'(dbg_data), 32'(pend_w[9:2]));
        check("flag_c", 32'(flag_c), 32'(pend_w[1] & FLAGS_EN));
        check("flag_z", 32'(flag_z), 32'(pend_w[0] & FLAGS_EN));
        pend = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          pend_w = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
          dbg_addr_mon = pend_w[11:10];
          pend = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.instr_ready;
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic drive_fields(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    bus.instr_ldi = ldi;
    bus.instr_op  = op;
    bus.instr_rd  = rd;
    bus.instr_rs1 = rs1;
    bus.instr_rs2 = rs2;
    bus.instr_imm = imm;
  endtask

  task automatic push_exp(input logic ldi, input logic [W-1:0] exp_w);
    exp_q.push_back(exp_w);
    exp_cyc_q.push_back(cyc + (ldi ? 1 : 2));
    ref_regs[exp_w[11:10]] = exp_w[9:2];
    ref_c = exp_w[1];
    ref_z = exp_w[0];
  endtask

  task automatic send(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                      input logic [W-1:0] exp_w);
    bit ok;
    logic [7:0] a_exp, b_exp;
    logic [2:0] sel_exp;
    wait_ready(ok);
    if (!ok) return;
    a_exp   = ldi ? alu_a : ref_regs[rs1];
    b_exp   = ldi ? alu_b : ref_regs[rs2];
    sel_exp = ldi ? alu_sel : op;
    drive_fields(ldi, op, rd, rs1, rs2, imm);
    bus.instr_valid = 1'b1;
    push_exp(ldi, exp_w);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    drive_fields(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    @(negedge clk);
    check(ldi ? "ldi_alu_a_hold" : "issue_alu_a", 32'(alu_a), 32'(a_exp));
    check(ldi ? "ldi_alu_b_hold" : "issue_alu_b", 32'(alu_b), 32'(b_exp));
    check(ldi ? "ldi_alu_sel_hold" : "issue_alu_sel", 32'(alu_sel), 32'(sel_exp));
    check("busy_ready", 32'(bus.instr_ready), 32'(0));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || pend) fail_now("drain_timeout");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic       ldi;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] imm;
    logic [7:0] exp_d;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    bit ok;
    logic [W-1:0] w;
    logic rdy_pat [7];

    // LDI R0/R1, ADD 0x6F+0x6F, then 0xFF+0x01, then op sweep, then an LDI and an rs1=rs2=rd op
    vecs[0]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h6F, 8'h6F, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h6F, 8'h6F, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 8'hDE, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, OP_ADD, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h6F, 8'h6F, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h6F, 8'h6F, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 8'hDE, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, OP_SUB, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b0, OP_AND, 2'd2, 2'd0, 2'd1, 8'h00, 8'h6F, 1'b0, 1'b0};
    vecs[11] = '{1'b0, OP_OR,  2'd3, 2'd0, 2'd1, 8'h00, 8'h6F, 1'b0, 1'b0};
    vecs[12] = '{1'b0, OP_XOR, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[13] = '{1'b0, OP_NOT, 2'd3, 2'd0, 2'd1, 8'h00, 8'h90, 1'b0, 1'b0};
    vecs[14] = '{1'b0, OP_SHL, 2'd2, 2'd0, 2'd1, 8'h00, 8'hDE, 1'b0, 1'b0};
    vecs[15] = '{1'b0, OP_SHR, 2'd3, 2'd0, 2'd1, 8'h00, 8'h37, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[17] = '{1'b0, OP_ADD, 2'd1, 2'd1, 2'd1, 8'h00, 8'hDE, 1'b0, 1'b0};

    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_c = 1'b0;
    ref_z = 1'b0;
    dbg_tb_own   = 1'b0;
    dbg_addr_tb  = 2'd0;
    dbg_addr_mon = 2'd0;
    bus.instr_valid = 1'b0;
    drive_fields(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);

    // power-on reset values
    #1;
    check("rst_alu_a", 32'(alu_a), 32'(0));
    check("rst_alu_sel", 32'(alu_sel), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(bus.instr_ready), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(bus.instr_ready), 32'(1));

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].ldi, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
           {vecs[i].rd, vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_z});
    end
    drain();

    // reset asserted during ISSUE aborts the op and clears everything
    wait_ready(ok);
    if (ok) begin
      drive_fields(1'b0, OP_ADD, 2'd3, 2'd0, 2'd1, 8'h00);
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_state", 32'(dbg_state), 32'(ST_ISSUE));
      rst_n = 1'b0;
      #1;
      check("midrst_alu_a", 32'(alu_a), 32'(0));
      check("midrst_alu_b", 32'(alu_b), 32'(0));
      check("midrst_alu_sel", 32'(alu_sel), 32'(0));
      check("midrst_done", 32'(done), 32'(0));
      check("midrst_flag_c", 32'(flag_c), 32'(0));
      check("midrst_flag_z", 32'(flag_z), 32'(0));
      check("midrst_ready", 32'(bus.instr_ready), 32'(0));
      check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
      dbg_tb_own = 1'b1;
      for (int r = 0; r < 4; r++) begin
        dbg_addr_tb = 2'(r);
        #1;
        check("midrst_reg", 32'(dbg_data), 32'(0));
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_after_midrst", 32'(bus.instr_ready), 32'(1));
      check("no_done_after_abort", 32'(done), 32'(0));
      dbg_tb_own = 1'b0;
      for (int r = 0; r < 4; r++) ref_regs[r] = 8'h00;
      ref_c = 1'b0;
      ref_z = 1'b0;
    end

    // instr_valid held high: accepts only every third cycle
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h11, model(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h11));
    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h22, model(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h22));
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    wait_ready(ok);
    if (ok) begin
      drive_fields(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00);
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
        if (i > 0) @(negedge clk);
        check("hold_valid_ready", 32'(bus.instr_ready), 32'(rdy_pat[i]));
        if (bus.instr_ready) push_exp(1'b0, model(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00));
      end
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
    end
    drain();

    // random instruction stream against the reference model
    for (int i = 0; i < 16; i++) begin
      logic       l;
      logic [2:0] o;
      logic [1:0] d, s1, s2;
      logic [7:0] im;
      l  = 1'($urandom_range(0, 1));
      o  = 3'($urandom_range(0, 7));
      d  = 2'($urandom_range(0, 3));
      s1 = 2'($urandom_range(0, 3));
      s2 = 2'($urandom_range(0, 3));
      im = 8'($urandom_range(0, 255));
      w  = model(l, o, d, s1, s2, im);
      send(l, o, d, s1, s2, im, w);
    end
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
